// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the TP5 fetch/PC stage: FSM states, opcode and PC-source encodings.
// Also holds the branch-take rule used by the next-PC selector.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10
  } fetch_state_e;

  localparam logic [3:0] OP_JUMP = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_RSV = 2'b11;

  // An unconditional write always wins, so ZERO only matters for the conditional write.
  function automatic logic pc_take(input logic esccp, input logic esccondcp, input logic zero);
    return esccp | (esccondcp & zero);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the control unit.
// The master modport is the fetch stage itself; slave is everything around it.
interface pc_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [3:0]         codop;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               esccp;
  logic               esccondcp;
  logic [1:0]         fontecp;
  logic               zero;
  logic               stall;
  logic [PC_W-1:0]    pc;

  modport master (
    output imem_req, imem_addr, codop, instr, instr_valid, pc,
    input  imem_ack, imem_data, esccp, esccondcp, fontecp, zero, stall
  );

  modport slave (
    input  imem_req, imem_addr, codop, instr, instr_valid, pc,
    output imem_ack, imem_data, esccp, esccondcp, fontecp, zero, stall
  );
endinterface

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Combinational next-PC selector: sequential, relative branch or absolute jump.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] imm,
  input  logic            esccp,
  input  logic            esccondcp,
  input  logic            zero,
  input  logic [1:0]      fontecp,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc + PC_W'(1);

  // The reserved source encoding falls back to sequential flow.
  always_comb begin
    pc_next = pc_inc;
    if (pc_take(esccp, esccondcp, zero)) begin
      case (fontecp)
        PC_BR:   pc_next = pc_inc + imm;
        PC_JMP:  pc_next = imm;
        default: pc_next = pc_inc;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch/PC stage of the TP5 multicycle core: FETCH -> DECODE -> EXEC loop holding PC and IR.
// IMEM_REQ and INSTR_VALID are registered from the next state so they change on clock edges only.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_fetch_unit_if.master bus
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_next;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_done;

  // An ACK only counts while a request is actually on the bus.
  assign fetch_done = (state_q == ST_FETCH) && imem_req_q && bus.imem_ack;

  pc_next_mux #(.PC_W(PC_W)) u_pc_next_mux (
    .pc       (pc_q),
    .imm      (ir_q[PC_W-1:0]),
    .esccp    (bus.esccp),
    .esccondcp(bus.esccondcp),
    .zero     (bus.zero),
    .fontecp  (bus.fontecp),
    .pc_next  (pc_next)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_done) begin
          ir_d    = bus.imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (!bus.stall) begin
          pc_d    = pc_next;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_DECODE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = ir_q;
  assign bus.codop       = ir_q[INSTR_W-1 -: 4];
  assign bus.instr_valid = instr_valid_q;

endmodule
